comm_rd_seq: RTL and testbench

- Parametrised multi-channel read-address sequencer for the UART transmit-buffer path.
- Each channel raises a request strobe. The block grants one channel at a time, round-robin.
- For the granted channel it steps a read address through NWORDS words, issuing one timed RD pulse per word slot, then signals completion per channel.
- Sits between the per-UART strobe sources and the shared frame buffer read port.

---
 rtl/comm_rd_seq.sv | 188 ++++++++++++++++++
 tb/tb_comm_rd_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/comm_rd_seq.sv
// comm_rd_seq: round-robin multi-channel read-address sequencer for the UART TX frame buffer.
// Define COMM_RD_ABORT_EN to abort a frame when its strobe drops; otherwise drops are ignored.
module comm_rd_seq #(
  parameter int unsigned NCH      = 5,
  parameter int unsigned NWORDS   = 18,
  parameter int unsigned AW       = 5,
  parameter int unsigned SLOT     = 64,
  parameter int unsigned RD_START = 40,
  parameter int unsigned RD_LEN   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH-1:0]         strob,
  output logic [NCH-1:0]         rd,
  output logic [NCH*AW-1:0]      rd_adr,
  output logic [NCH-1:0]         adr_valid,
  output logic                   busy,
  output logic [$clog2(NCH)-1:0] active_ch,
  output logic [NCH-1:0]         done,
  output logic [NCH-1:0]         abort
);

  localparam int unsigned CW = $clog2(NCH);
  localparam int unsigned SW = (SLOT > 1) ? $clog2(SLOT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SLOT = 2'd1,
    S_ADV  = 2'd2
  } state_t;

  state_t              state, state_d;
  logic [NCH-1:0]      strob_s1;
  logic [NCH-1:0]      req;
  logic [NCH-1:0]      armed, armed_d;
  logic [CW-1:0]       rr_ptr, rr_d;
  logic [SW-1:0]       slot, slot_d;
  logic [AW-1:0]       word, word_d;
  logic                busy_d;
  logic [CW-1:0]       ch_d;
  logic [NCH-1:0]      rd_d;
  logic [NCH*AW-1:0]   rd_adr_d;
  logic [NCH-1:0]      adr_valid_d;
  logic [NCH-1:0]      done_d;
  logic [NCH-1:0]      abort_d;
  logic                grant_vld;
  logic [CW-1:0]       grant_ch;
  int                  scan;
`ifdef COMM_RD_ABORT_EN
  logic                pend, pend_d;
`endif

  // Next-state, arbitration and output decode
  always_comb begin
    state_d     = state;
    slot_d      = slot;
    word_d      = word;
    busy_d      = busy;
    ch_d        = active_ch;
    rr_d        = rr_ptr;
    armed_d     = armed | ~req;
    rd_d        = '0;
    done_d      = '0;
    abort_d     = '0;
    rd_adr_d    = '0;
    adr_valid_d = '0;
    grant_vld   = 1'b0;
    grant_ch    = '0;
    scan        = 0;
`ifdef COMM_RD_ABORT_EN
    pend_d      = pend;
`endif

    for (int i = 0; i < int'(NCH); i++) begin
      scan = int'(rr_ptr) + i;
      if (scan >= int'(NCH)) scan = scan - int'(NCH);
      if (!grant_vld && req[scan[CW-1:0]] && armed[scan[CW-1:0]]) begin
        grant_vld = 1'b1;
        grant_ch  = scan[CW-1:0];
      end
    end

    unique case (state)
      S_IDLE: begin
        if (grant_vld) begin
          state_d = S_SLOT;
          busy_d  = 1'b1;
          ch_d    = grant_ch;
          rr_d    = (grant_ch == CW'(NCH - 1)) ? '0 : grant_ch + 1'b1;
          word_d  = '0;
          slot_d  = '0;
`ifdef COMM_RD_ABORT_EN
          pend_d  = 1'b0;
`endif
        end
      end
      S_SLOT: begin
        slot_d = slot + 1'b1;
        if (slot >= SW'(RD_START) && slot < SW'(RD_START + RD_LEN)) rd_d[active_ch] = 1'b1;
`ifdef COMM_RD_ABORT_EN
        if (!req[active_ch]) pend_d = 1'b1;
`endif
        if (slot == SW'(SLOT - 1)) begin
          slot_d  = '0;
          state_d = S_ADV;
`ifdef COMM_RD_ABORT_EN
          // Strobe dropped somewhere in this slot: finish it, then abort instead of advancing
          if (pend || !req[active_ch]) begin
            state_d            = S_IDLE;
            busy_d             = 1'b0;
            word_d             = '0;
            abort_d[active_ch] = 1'b1;
            armed_d[active_ch] = 1'b0;
            pend_d             = 1'b0;
          end
`endif
        end
      end
      S_ADV: begin
`ifdef COMM_RD_ABORT_EN
        if (!req[active_ch]) pend_d = 1'b1;
`endif
        if (word == AW'(NWORDS - 1)) begin
          state_d           = S_IDLE;
          busy_d            = 1'b0;
          word_d            = '0;
          done_d[active_ch] = 1'b1;
          armed_d[active_ch] = 1'b0;
`ifdef COMM_RD_ABORT_EN
          pend_d            = 1'b0;
`endif
        end else begin
          word_d  = word + 1'b1;
          slot_d  = '0;
          state_d = S_SLOT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    for (int k = 0; k < int'(NCH); k++) begin
      adr_valid_d[k]       = busy_d && (ch_d == CW'(k));
      rd_adr_d[k*AW +: AW] = adr_valid_d[k] ? word_d : '0;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      strob_s1  <= '0;
      req       <= '0;
      armed     <= '1;
      rr_ptr    <= '0;
      slot      <= '0;
      word      <= '0;
      busy      <= 1'b0;
      active_ch <= '0;
      rd        <= '0;
      rd_adr    <= '0;
      adr_valid <= '0;
      done      <= '0;
      abort     <= '0;
`ifdef COMM_RD_ABORT_EN
      pend      <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      strob_s1  <= strob;
      req       <= strob_s1;
      armed     <= armed_d;
      rr_ptr    <= rr_d;
      slot      <= slot_d;
      word      <= word_d;
      busy      <= busy_d;
      active_ch <= ch_d;
      rd        <= rd_d;
      rd_adr    <= rd_adr_d;
      adr_valid <= adr_valid_d;
      done      <= done_d;
      abort     <= abort_d;
`ifdef COMM_RD_ABORT_EN
      pend      <= pend_d;
`endif
    end
  end

endmodule

// File: tb/tb_comm_rd_seq.sv
// Directed bench for comm_rd_seq at default parameters: single frame, round-robin,
// re-arm, reset mid-frame and strobe drop (abort or ignore, depending on COMM_RD_ABORT_EN).
module tb_comm_rd_seq;

  localparam int NCH = 5;
  localparam int AW  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    strob;
  logic [NCH-1:0]    rd;
  logic [NCH*AW-1:0] rd_adr;
  logic [NCH-1:0]    adr_valid;
  logic              busy;
  logic [2:0]        active_ch;
  logic [NCH-1:0]    done;
  logic [NCH-1:0]    abort;

  int checks = 0;
  int errors = 0;
  int f_len, f_pulses, f_bad;
  logic [NCH-1:0] f_done;
  int n;
  int done4_cnt = 0;
  int abort_cnt = 0;
  int done4_base;

  comm_rd_seq dut (
    .clk       (clk),
    .rst       (rst),
    .strob     (strob),
    .rd        (rd),
    .rd_adr    (rd_adr),
    .adr_valid (adr_valid),
    .busy      (busy),
    .active_ch (active_ch),
    .done      (done),
    .abort     (abort)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done[4]) done4_cnt++;
    if (abort != '0) abort_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle(input int max, output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < max) begin
      tick(1);
      cnt++;
    end
  endtask

  // Walks one frame from its grant cycle, tallying RD pulse timing/width/address anomalies
  task automatic run_frame(input int ch);
    int   width;
    logic prev;
    f_len = 0; f_pulses = 0; f_bad = 0; width = 0; prev = 1'b0;
    while (busy === 1'b1 && f_len < 2000) begin
      tick(1);
      f_len++;
      if ((rd & ~(5'(1) << ch)) != '0) f_bad++;
      if (rd[ch] && !prev) begin
        if (f_len != 65 * f_pulses + 41) f_bad++;
        if (rd_adr[ch*AW +: AW] != AW'(f_pulses)) f_bad++;
        f_pulses++;
      end
      if (rd[ch]) width++;
      else if (prev) begin
        if (width != 4) f_bad++;
        width = 0;
      end
      if (busy && adr_valid != (5'(1) << ch)) f_bad++;
      prev = rd[ch];
    end
    f_done = done;
  endtask

  initial begin
    rst = 1'b0;
    strob = '0;
    #3;
    chk("reset_busy", busy, 0);
    chk("reset_rd", rd, 0);
    chk("reset_adr", rd_adr, 0);
    chk("reset_valid", adr_valid, 0);
    chk("reset_done", done, 0);
    tick(2);
    rst = 1'b1;
    tick(2);

    // single frame on channel 0
    strob[0] = 1'b1;
    tick(2);
    chk("t1_busy_early", busy, 0);
    tick(1);
    chk("t1_busy_grant", busy, 1);
    chk("t1_ch", active_ch, 0);
    chk("t1_valid", adr_valid, 5'h01);
    chk("t1_adr0", rd_adr, 0);
    run_frame(0);
    chk("t1_len", f_len, 1170);
    chk("t1_pulses", f_pulses, 18);
    chk("t1_bad", f_bad, 0);
    chk("t1_done", f_done, 5'h01);
    tick(1);
    chk("t1_done_pulse", done, 0);
    tick(20);
    chk("t1_no_retrigger", busy, 0);
    chk("t1_idle_valid", adr_valid, 0);

    // round robin: ch1 and ch3 together after reset
    rst = 1'b0;
    strob = '0;
    tick(1);
    rst = 1'b1;
    tick(2);
    strob = 5'b01010;
    tick(3);
    chk("t2_busy", busy, 1);
    chk("t2_first_ch", active_ch, 1);
    run_frame(1);
    chk("t2_ch1_len", f_len, 1170);
    chk("t2_ch1_bad", f_bad, 0);
    chk("t2_ch1_done", f_done, 5'h02);
    tick(1);
    chk("t2_second_busy", busy, 1);
    chk("t2_second_ch", active_ch, 3);
    tick(100);
    strob[1] = 1'b0;
    tick(3);
    strob[1] = 1'b1;
    tick(3);
    chk("t2_ch3_kept", active_ch, 3);
    wait_idle(1200, n);
    chk("t2_ch3_rest", n, 1064);
    chk("t2_ch3_done", done, 5'h08);
    tick(1);
    chk("t2_ch1_again_busy", busy, 1);
    chk("t2_ch1_again_ch", active_ch, 1);

    // re-arm on channel 2
    rst = 1'b0;
    strob = '0;
    tick(1);
    rst = 1'b1;
    tick(2);
    strob[2] = 1'b1;
    tick(3);
    chk("t3_ch", active_ch, 2);
    wait_idle(1200, n);
    chk("t3_len", n, 1170);
    chk("t3_done", done, 5'h04);
    tick(5);
    chk("t3_held_idle", busy, 0);
    strob[2] = 1'b0;
    tick(1);
    strob[2] = 1'b1;
    tick(2);
    chk("t3_rearm_early", busy, 0);
    tick(1);
    chk("t3_rearm_busy", busy, 1);
    chk("t3_rearm_ch", active_ch, 2);

    // reset at word 7, slot 42
    tick(497);
    chk("t4_rd_high", rd, 5'h04);
    chk("t4_adr", rd_adr, 64'h1C00);
    rst = 1'b0;
    #1;
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_rd", rd, 0);
    chk("t4_rst_adr", rd_adr, 0);
    chk("t4_rst_valid", adr_valid, 0);
    tick(1);
    chk("t4_rst_done", done, 0);
    rst = 1'b1;
    tick(2);
    chk("t4_rereq_early", busy, 0);
    tick(1);
    chk("t4_rereq_busy", busy, 1);
    chk("t4_rereq_ch", active_ch, 2);

    // strobe drop on channel 4 at word 5, slot 10
    rst = 1'b0;
    strob = '0;
    tick(1);
    rst = 1'b1;
    tick(2);
    abort_cnt = 0;
    strob[4] = 1'b1;
    tick(3);
    chk("t5_ch", active_ch, 4);
    done4_base = done4_cnt;
    tick(335);
    chk("t5_adr_w5", rd_adr, 64'h50_0000);
    strob[4] = 1'b0;
    tick(31);
    chk("t5_rd_in_flight", rd, 5'h10);
    tick(22);
    chk("t5_busy_slot63", busy, 1);
    chk("t5_no_abort_yet", abort, 0);
    tick(1);
`ifdef COMM_RD_ABORT_EN
    chk("t5_abort", abort, 5'h10);
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_done", done, 0);
    tick(1);
    chk("t5_abort_pulse", abort, 0);
    tick(100);
    chk("t5_no_done", done4_cnt - done4_base, 0);
    chk("t5_abort_count", abort_cnt, 1);
`else
    chk("t5_abort_tied", abort, 0);
    chk("t5_still_busy", busy, 1);
    chk("t5_adr_adv", rd_adr, 64'h50_0000);
    wait_idle(1200, n);
    chk("t5_rest", n, 781);
    chk("t5_done", done, 5'h10);
    tick(1);
    chk("t5_done_count", done4_cnt - done4_base, 1);
    chk("t5_abort_never", abort_cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
